// File: rtl/cp0_ctrl_if.sv
// Pipeline-side bundle for the CP0 exception controller: mfc0/mtc0 access,
// M-stage victim information, interrupt lines and the redirect/return outputs.
interface cp0_ctrl_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] CP0In;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        req;
  logic [31:0] EPCOut;
  logic [31:0] CP0Out;

  modport master (
    output A1, A2, CP0In, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  req, EPCOut, CP0Out
  );

  modport slave (
    input  A1, A2, CP0In, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output req, EPCOut, CP0Out
  );
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception controller: holds SR/Cause/EPC, raises the fetch
// redirect request and serves mfc0/mtc0 and the eret return address.
module cp0_ctrl #(
  parameter logic [31:0] PRID = 32'h2023_0007
) (
  input logic       clk,
  input logic       rst_n,
  cp0_ctrl_if.slave bus
);

  typedef enum logic [4:0] {
    REG_SR    = 5'd12,
    REG_CAUSE = 5'd13,
    REG_EPC   = 5'd14,
    REG_PRID  = 5'd15
  } cp0_reg_e;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req_int;
  logic        wr_sr;
  logic        wr_epc;

  assign int_req = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (bus.ExcCodeIn != '0) & ~sr_exl;
  assign req_int = (int_req | exc_req) & rst_n;

  assign wr_sr  = bus.WE & ~req_int & (bus.A2 == REG_SR);
  assign wr_epc = bus.WE & ~req_int & (bus.A2 == REG_EPC);

  assign bus.req = req_int;

  // Bypass is gated by rst_n so the return address reads 0 throughout reset.
  assign bus.EPCOut = !rst_n ? '0 : (wr_epc ? bus.CP0In : epc);

  always_comb begin
    bus.CP0Out = '0;
    case (bus.A1)
      REG_SR:    bus.CP0Out = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
      REG_CAUSE: bus.CP0Out = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'h0};
      REG_EPC:   bus.CP0Out = epc;
      REG_PRID:  bus.CP0Out = PRID;
      default:   bus.CP0Out = '0;
    endcase
  end

  // EXLClr is applied before the mtc0 write so an SR write decides EXL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.HWInt;
      if (req_int) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.BDIn;
        cause_exc <= int_req ? 5'd0 : bus.ExcCodeIn;
        epc       <= bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
      end else begin
        if (bus.EXLClr) begin
          sr_exl <= 1'b0;
        end
        if (wr_sr) begin
          sr_im  <= bus.CP0In[15:10];
          sr_exl <= bus.CP0In[1];
          sr_ie  <= bus.CP0In[0];
        end
        if (wr_epc) begin
          epc <= bus.CP0In;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_cp0_ctrl;

  localparam logic [31:0] PRID_VAL = 32'h2023_0007;
  localparam int K_REQ = 0;
  localparam int K_CP0 = 1;
  localparam int K_EPC = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  cp0_ctrl_if bus ();

  cp0_ctrl #(.PRID(PRID_VAL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REQ:   got = {31'h0, bus.req};
        K_CP0:   got = bus.CP0Out;
        default: got = bus.EPCOut;
      endcase
      n_cmp++;
      if (got !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.val);
      end
    end
  end

  task automatic expect_val(input string nm, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.A1 = '0; bus.A2 = '0; bus.CP0In = '0; bus.WE = 1'b0;
    bus.VPC = '0; bus.BDIn = 1'b0; bus.ExcCodeIn = '0; bus.HWInt = '0;
    bus.EXLClr = 1'b0;
    step();

    // reset held with a pending exception code
    bus.ExcCodeIn = 5'd4; bus.A1 = 5'd12;
    expect_val("rst_req", K_REQ, 32'h0);
    expect_val("rst_sr", K_CP0, 32'h0);
    step();
    bus.A1 = 5'd15; bus.WE = 1'b1; bus.A2 = 5'd14; bus.CP0In = 32'h1234;
    expect_val("rst_prid", K_CP0, PRID_VAL);
    expect_val("rst_epcout", K_EPC, 32'h0);
    step();
    bus.WE = 1'b0;
    rst_n = 1'b1; bus.VPC = 32'h100;
    expect_val("post_rst_req", K_REQ, 32'h1);
    step();
    bus.ExcCodeIn = '0; bus.A1 = 5'd13;
    expect_val("post_rst_cause", K_CP0, 32'h0000_0010);
    expect_val("post_rst_req_exl", K_REQ, 32'h0);
    step();
    bus.A1 = 5'd12; bus.EXLClr = 1'b1;
    expect_val("post_rst_sr", K_CP0, 32'h0000_0002);
    step();

    // plain exception
    bus.EXLClr = 1'b0; bus.ExcCodeIn = 5'd10; bus.VPC = 32'h3008; bus.A1 = 5'd12;
    expect_val("exc_sr_clr", K_CP0, 32'h0);
    expect_val("exc_req", K_REQ, 32'h1);
    step();
    bus.ExcCodeIn = '0; bus.A1 = 5'd14;
    expect_val("exc_epc", K_CP0, 32'h0000_3008);
    expect_val("exc_req_off", K_REQ, 32'h0);
    step();
    bus.A1 = 5'd13;
    expect_val("exc_cause", K_CP0, 32'h0000_0028);
    step();
    bus.A1 = 5'd12; bus.EXLClr = 1'b1;
    expect_val("exc_sr_exl", K_CP0, 32'h0000_0002);
    step();

    // delay-slot exception
    bus.EXLClr = 1'b0; bus.BDIn = 1'b1; bus.VPC = 32'h3010; bus.ExcCodeIn = 5'd4;
    expect_val("bd_req", K_REQ, 32'h1);
    step();
    bus.BDIn = 1'b0; bus.ExcCodeIn = '0; bus.A1 = 5'd14;
    expect_val("bd_epc", K_CP0, 32'h0000_300C);
    step();
    bus.A1 = 5'd13; bus.EXLClr = 1'b1;
    expect_val("bd_cause", K_CP0, 32'h8000_0010);
    step();

    // interrupt enabled through IM[0]
    bus.EXLClr = 1'b0; bus.WE = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0401;
    bus.VPC = 32'h4000;
    expect_val("int_wr_req", K_REQ, 32'h0);
    step();
    bus.WE = 1'b0; bus.HWInt = 6'b000001; bus.A1 = 5'd12;
    expect_val("int_sr", K_CP0, 32'h0000_0401);
    expect_val("int_req", K_REQ, 32'h1);
    step();
    bus.A1 = 5'd13;
    expect_val("int_cause", K_CP0, 32'h0000_0400);
    expect_val("int_req_exl", K_REQ, 32'h0);
    step();

    // interrupt masked by IM
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0001;
    step();
    bus.WE = 1'b0; bus.A1 = 5'd12;
    expect_val("mask_sr", K_CP0, 32'h0000_0001);
    expect_val("mask_req", K_REQ, 32'h0);
    step();
    bus.A1 = 5'd13;
    expect_val("mask_ip", K_CP0, 32'h0000_0400);
    step();

    // interrupt beats a simultaneous exception
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0401;
    step();
    bus.WE = 1'b0; bus.ExcCodeIn = 5'd12; bus.VPC = 32'h5550;
    expect_val("prio_req", K_REQ, 32'h1);
    step();
    bus.ExcCodeIn = '0; bus.A1 = 5'd13;
    expect_val("prio_cause", K_CP0, 32'h0000_0400);
    step();

    // mtc0 EPC dropped while req is high
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0401;
    expect_val("drop_pre_req", K_REQ, 32'h0);
    step();
    bus.A2 = 5'd14; bus.CP0In = 32'h0000_5000; bus.VPC = 32'h6000;
    expect_val("drop_req", K_REQ, 32'h1);
    expect_val("drop_epcout", K_EPC, 32'h0000_5550);
    step();
    bus.WE = 1'b0; bus.A1 = 5'd14;
    expect_val("drop_epc", K_CP0, 32'h0000_6000);
    step();

    // eret path: EPCOut bypass, then EXL clear re-arms the interrupt
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.CP0In = 32'h0000_3100;
    expect_val("bypass_epcout", K_EPC, 32'h0000_3100);
    step();
    bus.WE = 1'b0; bus.EXLClr = 1'b1;
    expect_val("ret_epcout", K_EPC, 32'h0000_3100);
    expect_val("ret_req_held", K_REQ, 32'h0);
    step();
    bus.A1 = 5'd12;
    expect_val("ret_req_again", K_REQ, 32'h1);
    expect_val("ret_sr", K_CP0, 32'h0000_0401);
    step();

    // EXLClr alongside req leaves EXL set
    bus.EXLClr = 1'b0;
    expect_val("clr_vs_req_sr", K_CP0, 32'h0000_0403);
    expect_val("clr_vs_req_req", K_REQ, 32'h0);
    step();

    // mtc0 SR wins over EXLClr
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.CP0In = 32'h0000_0403; bus.EXLClr = 1'b1;
    step();
    bus.WE = 1'b0; bus.EXLClr = 1'b0;
    expect_val("wr_vs_clr_sr", K_CP0, 32'h0000_0403);
    step();

    // asynchronous reset mid-handler
    rst_n = 1'b0;
    #1;
    expect_val("async_rst_sr", K_CP0, 32'h0);
    expect_val("async_rst_req", K_REQ, 32'h0);
    step();
    rst_n = 1'b1;
    expect_val("after_rst_req", K_REQ, 32'h0);
    step();

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception controller for the pipelined MIPS core. It sits beside the M stage and takes the victim PC, branch-delay flag, exception code and hardware interrupt lines. It asserts `req` to redirect fetch to the handler, and holds SR/Cause/EPC. It returns EPC to the fetch stage for `eret`, and serves `mfc0`/`mtc0` accesses.

## Interface
Parameters:
- `PRID`, default 32'h2023_0007, value returned on reads of register 15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `A1`  in  5  `mfc0` read register number
- `A2`  in  5  `mtc0` write register number
- `CP0In`  in  32  `mtc0` write data
- `WE`  in  1  `mtc0` write enable (M stage)
- `VPC`  in  32  PC of the M-stage instruction (victim)
- `BDIn`  in  1  M-stage instruction sits in a branch delay slot
- `ExcCodeIn`  in  5  M-stage exception code; 0 means none
- `HWInt`  in  6  external interrupt lines, level-sensitive
- `EXLClr`  in  1  `eret` committing (clears EXL)
- `req`  out  1  exception/interrupt taken this cycle (combinational)
- `EPCOut`  out  32  return address for `eret`, with bypass
- `CP0Out`  out  32  `mfc0` read data (combinational)

## Operation
Register fields:
- SR (12): IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
- Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]. All other bits read 0. Not writable by `mtc0`.
- EPC (14): full 32 bits, writable.
- 15: reads `PRID`. Any other address reads 0.

Request logic:
- IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
- ExcReq = (ExcCodeIn != 0) & !SR.EXL.
- `req` = (IntReq | ExcReq) & rst_n.

On an edge with `req`=1:
- EXL is set to 1.
- BD is loaded from `BDIn`.
- ExcCode is loaded with 0 if IntReq, else `ExcCodeIn`. Interrupts take priority over synchronous exceptions.
- EPC is loaded with `BDIn` ? `VPC`-4 : `VPC`, wrapping modulo 2^32.

`mtc0` writes:
- Take effect only when `WE` & !`req`.
- A2=12 loads IM/EXL/IE from the matching bits of `CP0In`.
- A2=14 loads EPC.
- All other addresses are ignored.

`EXLClr` clears EXL when `req`=0.

Cause.IP is loaded from `HWInt` on every edge, regardless of `req`, `WE` or EXL.

`EPCOut` bypass: equals `CP0In` when `WE` & A2=14 & !`req`; otherwise the EPC register.

## Timing
- Reset (`rst_n`=0, asynchronous): SR, Cause and EPC are 0. Outputs during reset: `req`=0, `EPCOut`=0, `CP0Out`=0 except A1=15, which returns `PRID`.
- Deassertion of `rst_n` is synchronized externally; the first active edge after deassertion performs a normal update.
- `req` has zero-cycle latency from its inputs. Register effects are visible one edge later.
- `CP0Out` is combinational from the registers, with no bypass. An `mtc0`/`mfc0` pair to the same register is resolved by pipeline stalls, not here.

Simultaneous events:
- `req` & `WE`: the write is dropped.
- `req` & `EXLClr`: EXL ends at 1.
- `WE` to SR & `EXLClr`: the `mtc0` value for EXL wins.

While EXL=1:
- No new `req` is generated.
- Cause.BD, Cause.ExcCode and EPC are frozen.
- Cause.IP still tracks `HWInt`.

Reset asserted mid-handler clears EXL immediately, with no clock edge needed.

## Test plan
- Reset: hold `rst_n`=0 with `ExcCodeIn`=4 -> `req`=0 and `CP0Out`(A1=12)=0. Release, next edge -> `req`=1.
- Exception: `ExcCodeIn`=10, `VPC`=0x3008, `BDIn`=0 -> `req`=1 the same cycle. Next edge: EPC=0x3008, Cause=0x0000_0028, SR.EXL=1, `req`=0.
- Delay-slot exception: `BDIn`=1, `VPC`=0x3010, `ExcCodeIn`=4 -> EPC=0x300C and Cause[31]=1.
- Interrupt masking:
  - SR=0x0000_0401 via `mtc0`, then `HWInt`=6'b000001 -> `req`=1 and ExcCode=0.
  - Same with SR=0x0000_0001 -> `req`=0, and Cause.IP still reads 0x0000_0400.
- Priority: `ExcCodeIn`=12 and an enabled interrupt in the same cycle -> ExcCode=0. Separately, `WE`=1, A2=14, `CP0In`=0x5000 with `req`=1 -> EPC holds `VPC`, not 0x5000.
- Return:
  - `mtc0` EPC=0x3100 in the same cycle as a probe -> `EPCOut`=0x3100 immediately.
  - `EXLClr`=1 -> EXL=0 next edge, and pending enabled interrupts raise `req` again.
